// File: rtl/egress_buffer.sv
// ---------------------------------------------------------------------------
// egress_buffer
//   Small FWFT FIFO between the encryption top-level and the host side.
//   Captures one 64-bit word (plus its error tag) per upstream handshake using
//   a three-state capture FSM. The FSM makes sure a word that upstream keeps
//   asserting is never taken twice. The host sees the head entry
//   combinationally and pops it with host_ready.
//
// Parameters
//   DEPTH      : FIFO entries, power of two, 2..16
//
// Ports
//   clk        : rising-edge clock for all state
//   rst        : asynchronous active-low reset, 0 clears all state
//   enc_data   : upstream data word
//   enc_valid  : upstream word valid, held until acknowledged
//   enc_error  : upstream error flag, marks enc_data as an error code
//   enc_rcvd   : registered one-cycle acknowledge to upstream
//   host_data  : head-of-FIFO data word
//   host_err   : error tag of head entry
//   host_valid : head entry present
//   host_ready : host consumes head entry when high with host_valid
//   count      : current occupancy, 0..DEPTH
//   error_seen : sticky, an error-tagged word was accepted since reset
// ---------------------------------------------------------------------------
module egress_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [63:0]                enc_data,
   input  logic                       enc_valid,
   input  logic                       enc_error,
   output logic                       enc_rcvd,
   output logic [63:0]                host_data,
   output logic                       host_err,
   output logic                       host_valid,
   input  logic                       host_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       error_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } cap_state_t;

   cap_state_t        state, state_next;
   logic [64:0]       mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              full;
   logic              push, pop;

   // Fullness uses the occupancy before the edge, so a pop in the same
   // cycle cannot make room for a push while the FIFO is full.
   assign full = (count == CW'(DEPTH));
   assign pop  = host_valid && host_ready;

   always_comb begin
      state_next = state;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (enc_valid && !full) begin
               push       = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            state_next = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!enc_valid) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // enc_rcvd is a flop that tracks entry into ACK, so it is high exactly
   // for the cycle the FSM spends in ACK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         enc_rcvd <= 1'b0;
      end else begin
         state    <= state_next;
         enc_rcvd <= (state_next == ACK);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         error_seen <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && enc_error) error_seen <= 1'b1;
      end
   end

   // Storage is not reset; its content is don't-care while host_valid is low.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {enc_error, enc_data};
   end

   assign host_valid = (count != '0);
   assign host_err   = mem[rd_ptr][64];
   assign host_data  = mem[rd_ptr][63:0];

endmodule

// File: tb/tb_egress_buffer.sv
// ---------------------------------------------------------------------------
// tb_egress_buffer
//   Directed bench for egress_buffer (DEPTH=4). Words are pushed into a
//   scoreboard queue when driven upstream, and popped and compared when the
//   host side consumes them. Inputs change and outputs are sampled 1 ns after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_egress_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   enc_data;
   logic          enc_valid;
   logic          enc_error;
   logic          enc_rcvd;
   logic [63:0]   host_data;
   logic          host_err;
   logic          host_valid;
   logic          host_ready;
   logic [CW-1:0] count;
   logic          error_seen;

   int            vectors    = 0;
   int            miscompares = 0;
   logic [64:0]   sb [$];

   egress_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .enc_data   (enc_data),
      .enc_valid  (enc_valid),
      .enc_error  (enc_error),
      .enc_rcvd   (enc_rcvd),
      .host_data  (host_data),
      .host_err   (host_err),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .count      (count),
      .error_seen (error_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for the acknowledge pulse; returns with it visible.
   task automatic wait_rcvd(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (enc_rcvd) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, 65'(got), 65'(1'b1));
   endtask

   // Full upstream handshake; returns with the capture FSM back in IDLE.
   task automatic send_word(input logic [63:0] d, input logic e, input string tag);
      enc_data  = d;
      enc_error = e;
      enc_valid = 1'b1;
      sb.push_back({e, d});
      wait_rcvd(tag);
      enc_valid = 1'b0;
      tick();
      tick();
   endtask

   // Compare head against the scoreboard, then consume it on the next edge.
   task automatic pop_one(input string tag);
      logic [64:0] exp;
      check({tag, "_valid"}, 65'(host_valid), 65'(1'b1));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 65'(1'b1), 65'(1'b0));
      end else begin
         exp = sb.pop_front();
         check(tag, {host_err, host_data}, exp);
      end
      host_ready = 1'b1;
      tick();
      host_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [64:0] exp;

      rst        = 1'b0;
      enc_data   = '0;
      enc_valid  = 1'b0;
      enc_error  = 1'b0;
      host_ready = 1'b0;
      #2;
      check("rst_count",      65'(count),      65'(0));
      check("rst_host_valid", 65'(host_valid), 65'(0));
      check("rst_rcvd",       65'(enc_rcvd),   65'(0));
      check("rst_error_seen", 65'(error_seen), 65'(0));
      #21 rst = 1'b1;
      tick();
      tick();
      check("post_rst_no_capture", 65'(count), 65'(0));

      // Single word held three cycles: one write, one acknowledge.
      enc_data  = 64'hA5A5_0000_1234_5678;
      enc_error = 1'b0;
      enc_valid = 1'b1;
      sb.push_back({1'b0, 64'hA5A5_0000_1234_5678});
      pulses = 0;
      tick();
      check("single_latency_valid", 65'(host_valid), 65'(1));
      check("single_latency_data",  65'(host_data),  65'(64'hA5A5_0000_1234_5678));
      if (enc_rcvd) pulses++;
      tick();
      if (enc_rcvd) pulses++;
      tick();
      if (enc_rcvd) pulses++;
      enc_valid = 1'b0;
      tick();
      tick();
      check("single_pulses", 65'(pulses), 65'(1));
      check("single_count",  65'(count),  65'(1));
      check("single_err",    65'(host_err), 65'(0));
      pop_one("single_pop");
      check("single_drained", 65'(count), 65'(0));

      // Fill to DEPTH, fifth word stalls until a pop frees room.
      for (int i = 1; i <= 4; i++) send_word(64'(i), 1'b0, "fill_rcvd");
      check("fill_count", 65'(count), 65'(4));
      enc_data  = 64'd5;
      enc_error = 1'b0;
      enc_valid = 1'b1;
      sb.push_back({1'b0, 64'd5});
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (enc_rcvd) pulses++;
      end
      check("full_no_rcvd", 65'(pulses), 65'(0));
      check("full_count",   65'(count),  65'(4));
      pop_one("fill_pop1");
      check("full_pop_no_push", 65'(enc_rcvd), 65'(0));
      check("full_pop_count",   65'(count),    65'(3));
      wait_rcvd("fifth_rcvd");
      enc_valid = 1'b0;
      tick();
      tick();
      check("fifth_count", 65'(count), 65'(4));
      for (int i = 0; i < 4; i++) pop_one("fill_order");
      check("fill_drained", 65'(count), 65'(0));

      // Simultaneous push and pop at count=2 over ten iterations.
      send_word(64'h100, 1'b0, "pp_pre");
      send_word(64'h101, 1'b0, "pp_pre");
      for (int i = 0; i < 10; i++) begin
         enc_data  = 64'h200 + 64'(i);
         enc_error = 1'(i % 3 == 0);
         enc_valid = 1'b1;
         sb.push_back({1'(i % 3 == 0), 64'h200 + 64'(i)});
         exp = sb.pop_front();
         check("pp_head", {host_err, host_data}, exp);
         host_ready = 1'b1;
         tick();
         host_ready = 1'b0;
         check("pp_rcvd",  65'(enc_rcvd), 65'(1));
         check("pp_count", 65'(count),    65'(2));
         enc_valid = 1'b0;
         tick();
         tick();
      end
      pop_one("pp_drain");
      pop_one("pp_drain");
      check("pp_drained", 65'(count), 65'(0));

      // Reset and confirm error_seen clears, then exercise the error path.
      rst = 1'b0;
      #2;
      rst = 1'b1;
      sb.delete();
      tick();
      check("err_pre_seen", 65'(error_seen), 65'(0));
      send_word(64'hDEAD_BEEF_0000_0001, 1'b1, "err_rcvd");
      check("err_tag",  65'(host_err),   65'(1));
      check("err_seen", 65'(error_seen), 65'(1));
      pop_one("err_pop");
      check("err_seen_sticky", 65'(error_seen), 65'(1));
      check("err_count",       65'(count),      65'(0));

      // Reset mid-handshake in ACK: acknowledge drops without a clock.
      send_word(64'h300, 1'b0, "rack_pre");
      enc_data  = 64'h301;
      enc_valid = 1'b1;
      tick();
      check("rack_in_ack", 65'(enc_rcvd), 65'(1));
      #3 rst = 1'b0;
      #1;
      check("rack_rcvd",  65'(enc_rcvd),   65'(0));
      check("rack_count", 65'(count),      65'(0));
      check("rack_valid", 65'(host_valid), 65'(0));
      enc_valid = 1'b0;
      #1 rst = 1'b1;
      sb.delete();
      tick();

      // Reset in WAIT_LOW with three words buffered.
      send_word(64'h400, 1'b0, "rwl_pre");
      send_word(64'h401, 1'b0, "rwl_pre");
      enc_data  = 64'h402;
      enc_valid = 1'b1;
      tick();
      tick();
      check("rwl_count3", 65'(count), 65'(3));
      #3 rst = 1'b0;
      #1;
      check("rwl_rcvd",  65'(enc_rcvd),   65'(0));
      check("rwl_count", 65'(count),      65'(0));
      check("rwl_valid", 65'(host_valid), 65'(0));
      enc_valid = 1'b0;
      #1 rst = 1'b1;
      sb.delete();
      tick();
      tick();
      check("rwl_no_capture", 65'(count), 65'(0));

      // Empty pop is ignored; the next word must still appear at the head.
      host_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("empty_count", 65'(count),      65'(0));
         check("empty_valid", 65'(host_valid), 65'(0));
      end
      host_ready = 1'b0;
      send_word(64'h500, 1'b0, "empty_push");
      send_word(64'h501, 1'b1, "empty_push");
      check("empty_after_count", 65'(count), 65'(2));
      pop_one("empty_after_pop");
      pop_one("empty_after_pop");
      check("final_count", 65'(count), 65'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
